// File: rtl/punc_core_p_if.sv
// Memory bus between the punc_core_p processor and its memory.
//   mem_req   : transaction request (master -> slave)
//   mem_we    : 1 = write, 0 = read, meaningful while mem_req = 1
//   mem_addr  : low ADDR_W bits of the 16-bit effective address
//   mem_wdata : write data
//   mem_rdata : read data, valid in the cycle mem_ready = 1
//   mem_ready : a transaction completes on a rising edge with mem_req = 1 and mem_ready = 1
interface punc_core_p_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/punc_core_p.sv
// punc_core_p: small 16-bit multi-cycle processor (FETCH/DECODE/EXEC/MEM/HALT).
// Ports:
//   clk, rst       : single clock, asynchronous active-high reset
//   mem            : memory bus master (request/ready handshake)
//   rf_debug_addr  : register file debug select
//   rf_debug_data  : combinational read of R[rf_debug_addr]
//   pc_debug_data  : current PC
//   nzp_debug      : current N,Z,P condition codes
//   halted         : high while in HALT
// All bus outputs are registered; their next values are derived from the
// next FSM state so a request is already on the bus when FETCH/MEM is entered.
module punc_core_p #(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] RESET_PC  = 16'h3000,
  parameter logic [2:0]  NZP_RESET = 3'b010
) (
  input  logic          clk,
  input  logic          rst,
  punc_core_p_if.master mem,
  input  logic [2:0]    rf_debug_addr,
  output logic [15:0]   rf_debug_data,
  output logic [15:0]   pc_debug_data,
  output logic [2:0]    nzp_debug,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_TRP = 4'b1111;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  // One-hot condition code of a result value.
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    logic [2:0] r;
    if (v[15]) begin
      r = 3'b100;
    end else if (v == 16'h0000) begin
      r = 3'b010;
    end else begin
      r = 3'b001;
    end
    return r;
  endfunction

  state_t            state_r, state_nx;
  logic [15:0]       pc_r, pc_nx;
  logic [15:0]       ir_r, ir_nx;
  logic [15:0]       ea_r, ea_nx;
  logic [2:0]        nzp_r, nzp_nx;
  logic [15:0]       rf_r [0:7];

  logic              rf_we_s;
  logic [2:0]        rf_wa_s;
  logic [15:0]       rf_wd_s;
  logic              done_s;
  logic [15:0]       sr1_s, sr2_s, alu_b_s, off9_s;
  logic              br_take_s;

  logic              req_r, req_nx;
  logic              we_r, we_nx;
  logic [ADDR_W-1:0] addr_r, addr_nx;
  logic [15:0]       wdata_r, wdata_nx;
  logic              halted_r, halted_nx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state, datapath updates and next bus outputs.
  always_comb begin
    state_nx  = state_r;
    pc_nx     = pc_r;
    ir_nx     = ir_r;
    ea_nx     = ea_r;
    nzp_nx    = nzp_r;
    rf_we_s   = 1'b0;
    rf_wa_s   = ir_r[11:9];
    rf_wd_s   = 16'h0000;
    done_s    = req_r & mem.mem_ready;
    sr1_s     = rf_r[ir_r[8:6]];
    sr2_s     = rf_r[ir_r[2:0]];
    alu_b_s   = ir_r[5] ? sext5(ir_r[4:0]) : sr2_s;
    off9_s    = sext9(ir_r[8:0]);
    br_take_s = (ir_r[11] & nzp_r[2]) | (ir_r[10] & nzp_r[1]) | (ir_r[9] & nzp_r[0]);

    case (state_r)
      S_FETCH: begin
        if (done_s) begin
          ir_nx    = mem.mem_rdata;
          pc_nx    = pc_r + 16'h0001;
          state_nx = S_DECODE;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_DECODE: begin
        if (ir_r[15:12] == OP_TRP) begin
          state_nx = S_HALT;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (ir_r[15:12])
          OP_ADD: begin
            rf_we_s = 1'b1;
            rf_wd_s = sr1_s + alu_b_s;
          end
          OP_AND: begin
            rf_we_s = 1'b1;
            rf_wd_s = sr1_s & alu_b_s;
          end
          OP_NOT: begin
            rf_we_s = 1'b1;
            rf_wd_s = ~sr1_s;
          end
          OP_LEA: begin
            rf_we_s = 1'b1;
            rf_wd_s = pc_r + off9_s;
          end
          OP_BR: begin
            if (br_take_s) begin
              pc_nx = pc_r + off9_s;
            end else begin
              pc_nx = pc_r;
            end
          end
          OP_JMP: begin
            pc_nx = sr1_s;
          end
          OP_LD, OP_ST: begin
            ea_nx    = pc_r + off9_s;
            state_nx = S_MEM;
          end
          default: begin
            state_nx = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (done_s) begin
          state_nx = S_FETCH;
          // IR[12] distinguishes ST (0011) from LD (0010).
          if (!ir_r[12]) begin
            rf_we_s = 1'b1;
            rf_wd_s = mem.mem_rdata;
          end else begin
            rf_we_s = 1'b0;
          end
        end else begin
          state_nx = S_MEM;
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase

    // Every register-writing instruction also updates the condition codes.
    if (rf_we_s) begin
      nzp_nx = nzp_of(rf_wd_s);
    end else begin
      nzp_nx = nzp_r;
    end

    // Bus outputs for the cycle after this edge; inputs to them are held
    // while waiting, so a stalled request stays stable.
    req_nx    = 1'b0;
    we_nx     = 1'b0;
    addr_nx   = addr_r;
    wdata_nx  = wdata_r;
    case (state_nx)
      S_FETCH: begin
        req_nx  = 1'b1;
        addr_nx = pc_nx[ADDR_W-1:0];
      end
      S_MEM: begin
        req_nx   = 1'b1;
        we_nx    = ir_nx[12];
        addr_nx  = ea_nx[ADDR_W-1:0];
        wdata_nx = rf_r[ir_nx[11:9]];
      end
      default: begin
        req_nx = 1'b0;
      end
    endcase
    halted_nx = (state_nx == S_HALT);
  end

  // Datapath registers and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      ir_r     <= 16'h0000;
      ea_r     <= 16'h0000;
      nzp_r    <= NZP_RESET;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= 16'h0000;
      halted_r <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_r[i] <= 16'h0000;
      end
    end else begin
      pc_r     <= pc_nx;
      ir_r     <= ir_nx;
      ea_r     <= ea_nx;
      nzp_r    <= nzp_nx;
      req_r    <= req_nx;
      we_r     <= we_nx;
      addr_r   <= addr_nx;
      wdata_r  <= wdata_nx;
      halted_r <= halted_nx;
      if (rf_we_s) begin
        rf_r[rf_wa_s] <= rf_wd_s;
      end
    end
  end

  assign mem.mem_req   = req_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;

  // Reads the current array contents, so a same-cycle write shows the old value.
  assign rf_debug_data = rf_r[rf_debug_addr];
  assign pc_debug_data = pc_r;
  assign nzp_debug     = nzp_r;
  assign halted        = halted_r;

endmodule
